// File: rtl/mode_ctrl_pkg.sv
// mode_ctrl_pkg: shared types and constants for the mode_ctrl button front end.
//   state_t   - debounce FSM states
//   MODE_UP   - mode_o value for counting up   (updown_counter.mode_i = 0)
//   MODE_DOWN - mode_o value for counting down (updown_counter.mode_i = 1)
package mode_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/mode_ctrl_btn_sync.sv
// btn_sync: two-flop synchroniser for the raw push-button.
//   clk_i   - clock
//   rst_i   - synchronous active-low reset, clears both flops to 0
//   async_i - raw asynchronous input
//   sync_o  - input synchronised to clk_i (two-cycle latency)
module btn_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic s1;
    logic s2;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= async_i;
            s2 <= s1;
        end
    end

    assign sync_o = s2;

endmodule

// File: rtl/mode_ctrl.sv
// mode_ctrl: debounces a raw push-button and toggles the up/down mode once
// per clean press. Optional long-press clear is enabled by defining
// MODE_CTRL_LONGPRESS_EN.
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-low reset
//   btn_i   - raw asynchronous button, active-high
//   mode_o  - mode to updown_counter (0 = up, 1 = down)
//   press_o - one-cycle pulse per accepted press
//   clr_o   - one-cycle long-press clear request (0 when feature absent)
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter  int unsigned DEBOUNCE_CYCLES = 4,
    parameter  int unsigned LONG_CYCLES     = 16,
    localparam int unsigned CNT_W           = $clog2(LONG_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic mode_o,
    output logic press_o,
    output logic clr_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             press_q;

`ifdef MODE_CTRL_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold;
    logic             clr_q;
`endif

    btn_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (btn_i),
        .sync_o  (btn_s)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= MODE_UP;
            press_q <= 1'b0;
`ifdef MODE_CTRL_LONGPRESS_EN
            hold    <= '0;
            clr_q   <= 1'b0;
`endif
        end else begin
            press_q <= 1'b0;
`ifdef MODE_CTRL_LONGPRESS_EN
            clr_q   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state   <= HELD;
                        mode_q  <= ~mode_q;
                        press_q <= 1'b1;
`ifdef MODE_CTRL_LONGPRESS_EN
                        hold    <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end
`ifdef MODE_CTRL_LONGPRESS_EN
                    else begin
                        // Saturating at LONG_CYCLES guarantees a single clear per hold,
                        // including across release bounces back into HELD.
                        if (hold == LONG_LAST) begin
                            clr_q  <= 1'b1;
                            mode_q <= MODE_UP;
                        end
                        if (hold != LONG_MAX) begin
                            hold <= hold + 1'b1;
                        end
                    end
`endif
                end
                REL_CHK: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mode_o  = mode_q;
    assign press_o = press_q;
`ifdef MODE_CTRL_LONGPRESS_EN
    assign clr_o   = clr_q;
`else
    assign clr_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mode_ctrl.sv
// tb_mode_ctrl: randomized and directed stimulus for mode_ctrl, checked cycle
// by cycle against a run-length reference model through an expectation queue.
module tb_mode_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned LONG = 16;
`ifdef MODE_CTRL_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk_i;
    logic rst_i;
    logic btn_i;
    logic mode_o;
    logic press_o;
    logic clr_o;

    int checks;
    int errors;

    typedef struct packed {
        logic mode;
        logic press;
        logic clr;
    } exp_t;

    exp_t exp_q[$];

    mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_i),
        .mode_o  (mode_o),
        .press_o (press_o),
        .clr_o   (clr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a press is accepted after DB+1 consecutive synchronised
    // high samples while released; a release after DB+1 consecutive lows.
    bit m_s1, m_s2;
    bit m_held;
    int m_run;
    int m_hold;
    bit m_mode;
    int m_presses;

    always @(posedge clk_i) begin
        exp_t e;
        bit   b;
        e = '0;
        if (!rst_i) begin
            m_s1 = 0; m_s2 = 0; m_held = 0; m_run = 0; m_hold = 0; m_mode = 0;
        end else begin
            b    = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_i;
            if (!m_held) begin
                m_run = b ? m_run + 1 : 0;
                if (m_run == DB + 1) begin
                    m_held = 1; m_run = 0; m_hold = 0;
                    m_mode = !m_mode;
                    e.press = 1'b1;
                    m_presses++;
                end
            end else if (!b) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_held = 0; m_run = 0;
                end
            end else begin
                if (LP && m_run == 0) begin
                    if (m_hold == LONG - 1) begin
                        e.clr  = 1'b1;
                        m_mode = 0;
                    end
                    if (m_hold < LONG) m_hold++;
                end
                m_run = 0;
            end
        end
        e.mode = m_mode;
        exp_q.push_back(e);
    end

    int seen_presses;

    always @(negedge clk_i) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t: no expectation queued", $time);
        end else begin
            e = exp_q.pop_front();
            if (press_o) seen_presses++;
            if ({mode_o, press_o, clr_o} !== {e.mode, e.press, e.clr}) begin
                errors++;
                $display("FAIL outputs t=%0t: got mode=%b press=%b clr=%b, want mode=%b press=%b clr=%b",
                         $time, mode_o, press_o, clr_o, e.mode, e.press, e.clr);
            end
        end
    end

    task automatic drive(input bit b, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            btn_i = b;
            rst_i = r;
        end
    endtask

    initial begin
        int  lat;
        bit  m0;
        bit  lvl;
        int  len;
        checks       = 0;
        errors       = 0;
        seen_presses = 0;
        m_presses    = 0;
        rst_i        = 1'b0;
        btn_i        = 1'b1;

        // Reset with button held, then release reset while still held.
        drive(1, 0, 2);
        drive(1, 1, 12);
        drive(0, 1, 12);

        // Clean press latency measured directly from the sampling edge.
        @(negedge clk_i);
        btn_i = 1'b1;
        m0    = mode_o;
        lat   = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk_i);
            #1;
            if (mode_o != m0 && lat < 0) lat = e;
        end
        checks++;
        if (lat != DB + 2) begin
            errors++;
            $display("FAIL press_latency: got %0d edges, want %0d", lat, DB + 2);
        end
        drive(0, 1, 10);

        // Second identical press, glitch, release bounce.
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(1, 1, 3);
        drive(0, 1, 10);
        drive(1, 1, 10);
        for (int i = 0; i < 6; i++) drive(i[0], 1, 1);
        drive(0, 1, 10);

        // Reset mid-debounce, button kept high afterwards.
        drive(1, 1, 4);
        drive(1, 0, 1);
        drive(1, 1, 12);
        drive(0, 1, 10);

        // Long press starting from mode down.
        drive(1, 1, 30);
        drive(0, 1, 10);
        drive(1, 1, 30);
        drive(0, 1, 10);

        // Randomized segments with occasional reset.
        for (int s = 0; s < 150; s++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(1, 10);
            if ($urandom_range(0, 24) == 0) drive(lvl, 0, 1);
            drive(lvl, 1, len);
        end
        drive(0, 1, 12);

        @(negedge clk_i);
        #1;
        checks++;
        if (seen_presses != m_presses) begin
            errors++;
            $display("FAIL press_count: got %0d, want %0d", seen_presses, m_presses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Upstream stage of updown_counter; produces its mode_i (0 = count up, 1 = count down) from a raw, bouncy push-button.
- Synchronises and debounces the button, then toggles the mode once per clean press.
- Emits a one-cycle press strobe for logging or benches.
- Optional long-press detection requests a counter clear and forces the mode back to up.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles the button must stay stable to accept a press or release; legal range ≥2.
- LONG_CYCLES, 16, cycles in HELD before a long press is declared; used only with the optional feature; must exceed DEBOUNCE_CYCLES.
- CNT_W, $clog2(LONG_CYCLES+1), width of the internal counters; derived, not overridden.

Ports:
- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-low (0 = reset, sampled on clk_i rising edge).
- btn_i  input  1  raw asynchronous button, active-high.
- mode_o  output  1  mode to updown_counter.mode_i; 0 = up, 1 = down.
- press_o  output  1  one-cycle pulse on each accepted press.
- clr_o  output  1  one-cycle long-press clear request; tied 0 when feature absent.

Behaviour:
- Reset (rst_i=0 at an edge): sync flops=0, state=IDLE, counters=0, mode_o=0, press_o=0, clr_o=0. Applies mid-operation from any state; any in-progress debounce is discarded.
- Synchroniser: two flops, btn_i -> s1 -> btn_s. FSM uses only btn_s.
- FSM states and transitions:
  - IDLE: btn_s=1 -> PRESS_CHK with cnt=0.
  - PRESS_CHK: btn_s=0 -> IDLE (glitch rejected, no toggle). btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1. btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; same edge: mode_o toggles, press_o=1 for exactly one cycle, hold counter cleared.
  - HELD: btn_s=0 -> REL_CHK with cnt=0.
  - REL_CHK: btn_s=1 -> HELD (release bounce ignored, no new press). btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
- Latency: with btn_i held high from sampling edge k, mode_o changes on edge k+DEBOUNCE_CYCLES+2.
  - For the default of 4, that is edge k+6.
- Press-while-held: only one toggle per HELD residency, regardless of hold length.
- Button held through reset release: the FSM starts in IDLE, sees btn_s=1, and accepts it as a new press after full debounce.
- Counters saturate; they never wrap.
- press_o and clr_o are registered and never high in the same cycle.

Optional Feature:
- Macro: MODE_CTRL_LONGPRESS_EN.
- Defined:
  - HELD increments a hold counter each cycle.
  - When it reaches LONG_CYCLES-1 with btn_s=1, clr_o pulses for one cycle and mode_o is forced to 0 on that edge.
  - The counter then saturates, so there is one clr_o per hold.
  - Leaving HELD for REL_CHK does not clear it; re-entry to HELD from REL_CHK continues counting. Entry from PRESS_CHK clears it.
- Undefined: no hold counter is present; clr_o is driven constant 0; HELD waits only for release.

Decomposition:
- Package mode_ctrl_pkg holds:
  - state enum: IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3;
  - MODE_UP=1'b0, MODE_DOWN=1'b1 constants, shared with updown_counter benches.
- Sub-module btn_sync: 2-flop synchroniser with synchronous active-low reset to 0. Instantiated once.

Test Plan:
- Reset: rst_i=0 for 2 edges with btn_i=1 -> mode_o=0, press_o=0, clr_o=0 throughout. Release reset with btn_i held -> one press accepted; mode_o=1 on edge 6 after release.
- Clean press: btn_i 0->1 sampled at edge k, held 10 cycles -> mode_o 0->1 at edge k+6; press_o high only during the cycle after k+6; no further toggle. Second identical press -> mode_o returns to 0.
- Glitch rejection: btn_i high for 3 cycles only -> mode_o unchanged, press_o never asserted.
- Release bounce: after an accepted press, btn_i toggles 1/0 every cycle for 6 cycles, then low -> no extra press_o; FSM ends in IDLE.
- Reset mid-debounce: rst_i=0 for one edge while in PRESS_CHK -> state IDLE, mode_o=0; the press does not complete without full re-debounce.
- Long press (MODE_CTRL_LONGPRESS_EN): mode_o=1, btn_i held 30 cycles -> toggle to 0 after debounce; clr_o single pulse LONG_CYCLES=16 cycles after HELD entry; mode_o stays 0. Without the macro -> clr_o constantly 0.
